// File: rtl/clap_approver_pkg.sv
// Shared types and constants for the clap/key approval path.
// No logic; pure declarations.
// No flow control; consumed by every file of the block.
package clap_approver_pkg;

   // Approval sequencer states; encoding is exported on state_dbg.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT2   = 2'd1,
      CONFIRM = 2'd2
   } state_t;

   // PS/2 set-2 prefix bytes.
   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;

   // Default answer keys: Y approves, N denies.
   localparam logic [7:0] KEY_YES_DEF = 8'h35;
   localparam logic [7:0] KEY_NO_DEF  = 8'h31;

endpackage

// File: rtl/clap_key_approver_if.sv
// Keyboard byte bus from the PS/2 receiver into the approver.
// Latency: none, wires only.
// No backpressure: key_valid is a one-cycle strobe that must be consumed.
interface clap_key_approver_if;
   logic       key_valid;
   logic [7:0] key_code;

   modport master (output key_valid, key_code);
   modport slave  (input  key_valid, key_code);
endinterface

// File: rtl/ps2_make_filter.sv
// Strips F0/E0 prefixes from the raw PS/2 byte stream, yielding make events.
// Latency: 0 cycles, outputs are combinational from the byte plus registered flags.
// No backpressure: every strobed byte is consumed in the cycle it arrives.
module ps2_make_filter
   import clap_approver_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       key_valid,
   input  logic [7:0] key_code,
   output logic       make_valid,
   output logic [7:0] make_code,
   output logic       make_ext
);

   logic brk_flag;
   logic ext_flag;
   logic is_prefix;

   assign is_prefix  = (key_code == PS2_BREAK) || (key_code == PS2_EXT);
   assign make_valid = key_valid && !brk_flag && !is_prefix;
   assign make_code  = key_code;
   assign make_ext   = ext_flag;

   // Prefix tracking: the byte after F0 is discarded and ends the whole
   // prefix sequence, so a pending E0 is dropped along with it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         brk_flag <= 1'b0;
         ext_flag <= 1'b0;
      end else if (key_valid) begin
         if (brk_flag) begin
            brk_flag <= 1'b0;
            ext_flag <= 1'b0;
         end else if (key_code == PS2_BREAK) begin
            brk_flag <= 1'b1;
         end else if (key_code == PS2_EXT) begin
            ext_flag <= 1'b1;
         end else begin
            ext_flag <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/clap_key_approver.sv
// Double clap arms the block; a Y/N keyboard answer approves or denies it.
// Latency: clap to state 3 cycles from first sample; key to pulse 1 cycle.
// No backpressure: clap edges during holdoff and unrelated keys are dropped.
module clap_key_approver
   import clap_approver_pkg::*;
#(
   parameter int unsigned HOLDOFF_CYC     = 5_000_000,
   parameter int unsigned PAIR_WINDOW_CYC = 50_000_000,
   parameter int unsigned CONFIRM_CYC     = 250_000_000,
   parameter logic [7:0]  KEY_YES         = KEY_YES_DEF,
   parameter logic [7:0]  KEY_NO          = KEY_NO_DEF
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      clap_detected,
   clap_key_approver_if.slave        kbd,
   output logic                      armed,
   output logic                      approved,
   output logic                      denied,
   output logic                      light_on,
   output logic [1:0]                state_dbg
);

   localparam int unsigned MAX_CYC = (PAIR_WINDOW_CYC > CONFIRM_CYC) ? PAIR_WINDOW_CYC : CONFIRM_CYC;
   localparam int TW = $clog2(MAX_CYC) + 1;
   localparam int HW = $clog2(HOLDOFF_CYC + 1);

   state_t          state;
   state_t          state_nx;
   logic [2:0]      clap_sync;
   logic            clap_rise;
   logic            clap_acc;
   logic [HW-1:0]   holdoff;
   logic [TW-1:0]   tmr_cnt;
   logic            tmr_zero;
   logic            tmr_load;
   logic [TW-1:0]   tmr_val;
   logic            approve_nx;
   logic            deny_nx;
   logic            make_valid;
   logic [7:0]      make_code;
   logic            make_ext;
   logic            key_yes;
   logic            key_no;

   ps2_make_filter u_filter (
      .clk        (clk),
      .resetn     (resetn),
      .key_valid  (kbd.key_valid),
      .key_code   (kbd.key_code),
      .make_valid (make_valid),
      .make_code  (make_code),
      .make_ext   (make_ext)
   );

   assign key_yes   = make_valid && !make_ext && (make_code == KEY_YES);
   assign key_no    = make_valid && !make_ext && (make_code == KEY_NO);
   assign clap_acc  = clap_rise && (holdoff == '0);
   assign tmr_zero  = (tmr_cnt == '0);
   assign state_dbg = state;

   // Two synchroniser flops, a third as edge-detect history, then a
   // registered rising-edge strobe.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         clap_sync <= '0;
         clap_rise <= 1'b0;
      end else begin
         clap_sync <= {clap_sync[1:0], clap_detected};
         clap_rise <= clap_sync[1] && !clap_sync[2];
      end
   end

   // Holdoff: every accepted edge, in any state, restarts the dead time.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         holdoff <= '0;
      end else if (clap_acc) begin
         holdoff <= HW'(HOLDOFF_CYC);
      end else if (holdoff != '0) begin
         holdoff <= holdoff - 1'b1;
      end
   end

   // Shared window/confirm timer; loaded with N-1 so the timed state
   // lasts exactly N cycles before the expiry cycle takes it out.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tmr_cnt <= '0;
      end else if (tmr_load) begin
         tmr_cnt <= tmr_val;
      end else if (!tmr_zero) begin
         tmr_cnt <= tmr_cnt - 1'b1;
      end
   end

   // Next-state and pulse decode; keys beat expiry, claps beat window expiry.
   always_comb begin
      state_nx   = state;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      approve_nx = 1'b0;
      deny_nx    = 1'b0;
      case (state)
         WAIT2: begin
            if (clap_acc) begin
               state_nx = CONFIRM;
               tmr_load = 1'b1;
               tmr_val  = TW'(CONFIRM_CYC - 1);
            end else if (tmr_zero) begin
               state_nx = IDLE;
            end
         end
         CONFIRM: begin
            if (key_yes) begin
               state_nx   = IDLE;
               approve_nx = 1'b1;
            end else if (key_no || tmr_zero) begin
               state_nx = IDLE;
               deny_nx  = 1'b1;
            end
         end
         default: begin
            if (clap_acc) begin
               state_nx = WAIT2;
               tmr_load = 1'b1;
               tmr_val  = TW'(PAIR_WINDOW_CYC - 1);
            end
         end
      endcase
   end

   // State and output registers; armed tracks the next state so it drops
   // in the same cycle the answer pulse rises.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         armed    <= 1'b0;
         approved <= 1'b0;
         denied   <= 1'b0;
         light_on <= 1'b0;
      end else begin
         state    <= state_nx;
         armed    <= (state_nx == CONFIRM);
         approved <= approve_nx;
         denied   <= deny_nx;
         if (approve_nx) begin
            light_on <= !light_on;
         end
      end
   end

endmodule

// File: tb/tb_clap_key_approver.sv
// Directed bench: key-byte vector table plus hand sequences for timing corners.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Every wait on the DUT is cycle-bounded.
module tb_clap_key_approver;

   logic       clk;
   logic       resetn;
   logic       clap_detected;
   logic       armed;
   logic       approved;
   logic       denied;
   logic       light_on;
   logic [1:0] state_dbg;

   clap_key_approver_if kbd_if ();

   clap_key_approver #(
      .HOLDOFF_CYC     (10),
      .PAIR_WINDOW_CYC (100),
      .CONFIRM_CYC     (200)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .clap_detected (clap_detected),
      .kbd           (kbd_if),
      .armed         (armed),
      .approved      (approved),
      .denied        (denied),
      .light_on      (light_on),
      .state_dbg     (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         arm;
      logic [7:0] code;
      bit         exp_apr;
      bit         exp_den;
      bit         exp_armed;
      bit         exp_light;
      logic [1:0] exp_state;
   } vec_t;

   localparam int NV = 18;
   vec_t vt [NV];

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;
   int armed_rise_cyc = 0;
   bit armed_q = 1'b0;
   bit saw_pulse = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (armed && !armed_q) armed_rise_cyc = cyc;
      armed_q = armed;
      if (approved || denied) saw_pulse = 1'b1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic double_clap();
      clap_detected = 1'b1; repeat (20) tick();
      clap_detected = 1'b0; repeat (30) tick();
      clap_detected = 1'b1; repeat (20) tick();
      clap_detected = 1'b0; tick();
   endtask

   task automatic send_key(input logic [7:0] code);
      kbd_if.key_valid = 1'b1;
      kbd_if.key_code  = code;
      tick();
      kbd_if.key_valid = 1'b0;
      kbd_if.key_code  = 8'h00;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300 && state_dbg != 2'd0; i++) tick();
      check("idle_reached", state_dbg, 0);
   endtask

   initial begin
      int e_cyc;
      // {arm first, byte, approved, denied, armed, light_on, state}
      vt[0]  = '{1, 8'h35, 1, 0, 0, 1, 2'd0};
      vt[1]  = '{1, 8'hF0, 0, 0, 1, 1, 2'd2};
      vt[2]  = '{0, 8'h35, 0, 0, 1, 1, 2'd2};
      vt[3]  = '{0, 8'hE0, 0, 0, 1, 1, 2'd2};
      vt[4]  = '{0, 8'h35, 0, 0, 1, 1, 2'd2};
      vt[5]  = '{0, 8'h12, 0, 0, 1, 1, 2'd2};
      vt[6]  = '{0, 8'h31, 0, 1, 0, 1, 2'd0};
      vt[7]  = '{0, 8'h35, 0, 0, 0, 1, 2'd0};
      vt[8]  = '{0, 8'hF0, 0, 0, 0, 1, 2'd0};
      vt[9]  = '{1, 8'h35, 0, 0, 1, 1, 2'd2};
      vt[10] = '{0, 8'h35, 1, 0, 0, 0, 2'd0};
      vt[11] = '{1, 8'hE0, 0, 0, 1, 0, 2'd2};
      vt[12] = '{0, 8'h31, 0, 0, 1, 0, 2'd2};
      vt[13] = '{0, 8'h31, 0, 1, 0, 0, 2'd0};
      vt[14] = '{1, 8'hE0, 0, 0, 1, 0, 2'd2};
      vt[15] = '{0, 8'hF0, 0, 0, 1, 0, 2'd2};
      vt[16] = '{0, 8'h35, 0, 0, 1, 0, 2'd2};
      vt[17] = '{0, 8'h35, 1, 0, 0, 1, 2'd0};

      resetn = 1'b0;
      clap_detected = 1'b0;
      kbd_if.key_valid = 1'b0;
      kbd_if.key_code  = 8'h00;
      repeat (3) tick();
      check("rst_armed", armed, 0);
      check("rst_approved", approved, 0);
      check("rst_denied", denied, 0);
      check("rst_light", light_on, 0);
      check("rst_state", state_dbg, 0);
      resetn = 1'b1;
      tick();
      check("post_rst_state", state_dbg, 0);

      // Clap latency: first sampled at the next edge, state moves 3 edges later.
      clap_detected = 1'b1;
      repeat (3) tick();
      check("clap_lat_early", state_dbg, 0);
      tick();
      check("clap_lat_wait2", state_dbg, 1);
      repeat (16) tick();
      clap_detected = 1'b0;
      wait_idle();

      // Second clap inside holdoff is dropped; window lapses silently.
      repeat (20) tick();
      saw_pulse = 1'b0;
      clap_detected = 1'b1; repeat (2) tick();
      clap_detected = 1'b0; repeat (3) tick();
      clap_detected = 1'b1; repeat (3) tick();
      clap_detected = 1'b0; repeat (95) tick();
      check("holdoff_still_wait2", state_dbg, 1);
      tick();
      check("window_expired_idle", state_dbg, 0);
      check("window_no_pulse", saw_pulse, 0);
      check("window_not_armed", armed, 0);

      // Clap 101 cycles after the first starts a fresh pair.
      repeat (20) tick();
      clap_detected = 1'b1; repeat (20) tick();
      clap_detected = 1'b0; repeat (81) tick();
      clap_detected = 1'b1; repeat (3) tick();
      check("late_clap_idle_first", state_dbg, 0);
      tick();
      check("late_clap_new_first", state_dbg, 1);
      repeat (16) tick();
      clap_detected = 1'b0;
      wait_idle();

      // Key-byte vector table.
      for (int i = 0; i < NV; i++) begin
         if (vt[i].arm) begin
            double_clap();
            check($sformatf("v%0d_armed_before", i), armed, 1);
         end
         send_key(vt[i].code);
         check($sformatf("v%0d_approved", i), approved, vt[i].exp_apr);
         check($sformatf("v%0d_denied", i), denied, vt[i].exp_den);
         check($sformatf("v%0d_armed", i), armed, vt[i].exp_armed);
         check($sformatf("v%0d_light", i), light_on, vt[i].exp_light);
         check($sformatf("v%0d_state", i), state_dbg, vt[i].exp_state);
      end
      tick();
      check("approve_pulse_width", approved, 0);

      // Timeout: denied exactly 200 cycles after armed rises.
      double_clap();
      check("to_armed", armed, 1);
      for (int i = 0; i < 400 && !denied; i++) tick();
      check("to_denied", denied, 1);
      check("to_delay", cyc - armed_rise_cyc, 200);
      check("to_armed_fell", armed, 0);
      check("to_light_kept", light_on, 1);
      tick();
      check("to_pulse_width", denied, 0);

      // Asynchronous reset while armed with the light on.
      double_clap();
      check("rstc_armed", armed, 1);
      check("rstc_light", light_on, 1);
      #1 resetn = 1'b0;
      #1;
      check("rstc_async_armed", armed, 0);
      check("rstc_async_light", light_on, 0);
      check("rstc_async_state", state_dbg, 0);
      check("rstc_async_pulses", {approved, denied}, 0);
      tick();
      resetn = 1'b1;
      tick();
      double_clap();
      check("rstc_rearmed", armed, 1);
      send_key(8'h35);
      check("rstc_approved", approved, 1);
      check("rstc_light_on", light_on, 1);

      // Yes key in the same cycle the confirm timer reads zero: key wins.
      repeat (5) tick();
      double_clap();
      check("sim_armed", armed, 1);
      e_cyc = armed_rise_cyc;
      for (int i = 0; i < 300 && cyc < e_cyc + 199; i++) tick();
      send_key(8'h35);
      check("sim_approved", approved, 1);
      check("sim_no_denied", denied, 0);
      check("sim_light", light_on, 0);
      tick();
      check("sim_no_late_deny", denied, 0);
      check("sim_state", state_dbg, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
